// File: rtl/sad_best_match_if.sv
// Handshake and result bundle between the SAD source, sad_best_match and its consumer.
// The slave modport is the block's view; the master modport is the driver/monitor view.
interface sad_best_match_if #(
  parameter int SAD_W = 10,
  parameter int ACC_W = 12,
  parameter int IDX_W = 4
);
  logic             start;
  logic [SAD_W-1:0] sad_in;
  logic             sad_valid;
  logic             sad_ready;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;

  modport slave (
    input  start, sad_in, sad_valid,
    output sad_ready, busy, done, best_sad, best_idx
  );

  modport master (
    output start, sad_in, sad_valid,
    input  sad_ready, busy, done, best_sad, best_idx
  );
endinterface

// File: rtl/sad_best_match.sv
// Accumulates SUBBLK 2x2 SADs per candidate block and tracks the minimum candidate
// sum and its index over NCAND candidates, signalling the winner with a done pulse.
module sad_best_match #(
  parameter int SAD_W  = 10,
  parameter int SUBBLK = 4,
  parameter int NCAND  = 16,
  parameter int ACC_W  = 12,
  parameter int IDX_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  sad_best_match_if.slave     bus
);
  localparam int               SUB_W     = $clog2(SUBBLK);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(SUBBLK - 1);
  localparam logic [IDX_W-1:0] CAND_LAST = IDX_W'(NCAND - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [SUB_W-1:0] r_sub;
  logic [IDX_W-1:0] r_cand;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_best_sad;
  logic [IDX_W-1:0] r_best_idx;
  logic             r_first;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;

  logic             w_xfer;
  logic [ACC_W-1:0] w_sum;

  // Strict less-than keeps the earliest candidate on ties.
  function automatic logic is_better(input logic             first,
                                     input logic [ACC_W-1:0] cand,
                                     input logic [ACC_W-1:0] best);
    return first || (cand < best);
  endfunction

  // ACC_W = SAD_W + log2(SUBBLK), so the candidate sum cannot wrap.
  assign w_xfer = bus.sad_valid && r_ready;
  assign w_sum  = r_acc + ACC_W'(bus.sad_in);

  assign bus.sad_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.best_sad  = r_best_sad;
  assign bus.best_idx  = r_best_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sub      <= '0;
      r_cand     <= '0;
      r_acc      <= '0;
      r_best_sad <= '1;
      r_best_idx <= '0;
      r_first    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_RUN;
            r_busy     <= 1'b1;
            r_ready    <= 1'b1;
            r_sub      <= '0;
            r_cand     <= '0;
            r_acc      <= '0;
            r_first    <= 1'b1;
            r_best_sad <= '1;
            r_best_idx <= '0;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            if (r_sub != SUB_LAST) begin
              r_acc <= w_sum;
              r_sub <= r_sub + SUB_W'(1);
            end else begin
              if (is_better(r_first, w_sum, r_best_sad)) begin
                r_best_sad <= w_sum;
                r_best_idx <= r_cand;
              end
              r_acc   <= '0;
              r_sub   <= '0;
              r_first <= 1'b0;
              if (r_cand == CAND_LAST) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_ready <= 1'b0;
              end else begin
                r_cand <= r_cand + IDX_W'(1);
              end
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sad_best_match.sv
// Directed bench: a 4-candidate instance for the main scenarios and a 1-candidate
// instance for the maximum-sum case.
module tb_sad_best_match;
  logic clk = 1'b0;
  logic rst;
  int   ncmp = 0;
  int   nerr = 0;
  int   nda  = 0;
  int   ndb  = 0;

  always #5 clk = ~clk;

  sad_best_match_if #(.SAD_W(10), .ACC_W(12), .IDX_W(4)) ia ();
  sad_best_match_if #(.SAD_W(10), .ACC_W(12), .IDX_W(4)) ib ();

  sad_best_match #(.SAD_W(10), .SUBBLK(4), .NCAND(4), .ACC_W(12), .IDX_W(4))
    u_a (.clk(clk), .rst(rst), .bus(ia));
  sad_best_match #(.SAD_W(10), .SUBBLK(4), .NCAND(1), .ACC_W(12), .IDX_W(4))
    u_b (.clk(clk), .rst(rst), .bus(ib));

  always @(posedge clk) begin
    if (ia.done) nda <= nda + 1;
    if (ib.done) ndb <= ndb + 1;
  end

  int d1 [16] = '{4, 4, 4, 4, 1, 1, 1, 1, 1020, 1020, 1020, 1020, 0, 0, 0, 1};
  int d2 [16] = '{4, 4, 4, 4, 16, 0, 0, 0, 0, 0, 0, 16, 5, 5, 5, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int v);
    ia.sad_in    = 10'(v);
    ia.sad_valid = 1'b1;
    tick();
    ia.sad_valid = 1'b0;
  endtask

  task automatic send_b(input int v);
    ib.sad_in    = 10'(v);
    ib.sad_valid = 1'b1;
    tick();
    ib.sad_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ia.start = 1'b0; ia.sad_valid = 1'b0; ia.sad_in = '0;
    ib.start = 1'b0; ib.sad_valid = 1'b0; ib.sad_in = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", 32'(ia.sad_ready), 0);
    check("rst_busy", 32'(ia.busy), 0);
    check("rst_done", 32'(ia.done), 0);
    check("rst_best_sad", 32'(ia.best_sad), 4095);
    check("rst_best_idx", 32'(ia.best_idx), 0);
    tick();
    check("idle_ready", 32'(ia.sad_ready), 0);

    // Basic search, no bubbles
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    check("s1_busy", 32'(ia.busy), 1);
    check("s1_ready", 32'(ia.sad_ready), 1);
    for (int i = 0; i < 16; i++) begin
      send_a(d1[i]);
      if (i == 3) begin
        check("s1_c0_sad", 32'(ia.best_sad), 16);
        check("s1_c0_idx", 32'(ia.best_idx), 0);
      end
      if (i == 7) begin
        check("s1_c1_sad", 32'(ia.best_sad), 4);
        check("s1_c1_idx", 32'(ia.best_idx), 1);
      end
      if (i == 11) check("s1_c2_sad", 32'(ia.best_sad), 4);
      if (i == 14) check("s1_early_done", 32'(ia.done), 0);
    end
    check("s1_done", 32'(ia.done), 1);
    check("s1_best_sad", 32'(ia.best_sad), 1);
    check("s1_best_idx", 32'(ia.best_idx), 3);
    check("s1_done_ready", 32'(ia.sad_ready), 0);
    check("s1_done_busy", 32'(ia.busy), 0);
    tick();
    check("s1_idle_done", 32'(ia.done), 0);
    check("s1_idle_ready", 32'(ia.sad_ready), 0);
    check("s1_hold_sad", 32'(ia.best_sad), 1);
    check("s1_hold_idx", 32'(ia.best_idx), 3);

    // Tie search, started in the first IDLE cycle after DONE
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    check("tie_busy", 32'(ia.busy), 1);
    check("tie_init_sad", 32'(ia.best_sad), 4095);
    check("tie_init_idx", 32'(ia.best_idx), 0);
    for (int i = 0; i < 16; i++) send_a(d2[i]);
    check("tie_done", 32'(ia.done), 1);
    check("tie_best_sad", 32'(ia.best_sad), 16);
    check("tie_best_idx", 32'(ia.best_idx), 0);
    tick();

    // Maximum candidate sum on the single-candidate instance
    ib.start = 1'b1; tick(); ib.start = 1'b0;
    for (int i = 0; i < 4; i++) send_b(1020);
    check("max_done", 32'(ib.done), 1);
    check("max_best_sad", 32'(ib.best_sad), 4080);
    check("max_best_idx", 32'(ib.best_idx), 0);
    tick();
    check("max_idle_done", 32'(ib.done), 0);

    // Same data as the basic search with valid gaps, including between sub-blocks
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ((i % 3) == 1 || i == 15) begin
        for (int g = 0; g <= (i % 4); g++) tick();
        check("bub_gap_done", 32'(ia.done), 0);
      end
      send_a(d1[i]);
    end
    check("bub_done", 32'(ia.done), 1);
    check("bub_best_sad", 32'(ia.best_sad), 1);
    check("bub_best_idx", 32'(ia.best_idx), 3);
    tick();

    // Reset after six transfers aborts the search without a done
    ia.start = 1'b1; tick(); ia.start = 1'b0;
    for (int i = 0; i < 6; i++) send_a(d1[i]);
    check("abort_pre_sad", 32'(ia.best_sad), 16);
    rst = 1'b1; tick(); rst = 1'b0;
    check("abort_ready", 32'(ia.sad_ready), 0);
    check("abort_busy", 32'(ia.busy), 0);
    check("abort_done", 32'(ia.done), 0);
    check("abort_best_sad", 32'(ia.best_sad), 4095);
    check("abort_best_idx", 32'(ia.best_idx), 0);
    for (int i = 0; i < 3; i++) begin
      ia.sad_in = 10'd7; ia.sad_valid = 1'b1;
      tick();
      check("abort_no_done", 32'(ia.done), 0);
    end
    ia.sad_valid = 1'b0;
    check("abort_ndone", 32'(nda), 3);

    // Fresh search with start held high through RUN and DONE
    ia.start = 1'b1; tick();
    check("held_busy", 32'(ia.busy), 1);
    check("held_ready", 32'(ia.sad_ready), 1);
    for (int i = 0; i < 16; i++) begin
      send_a(d1[i]);
      if (i == 14) check("held_early_done", 32'(ia.done), 0);
    end
    check("held_done", 32'(ia.done), 1);
    check("held_best_sad", 32'(ia.best_sad), 1);
    check("held_best_idx", 32'(ia.best_idx), 3);
    check("held_done_ready", 32'(ia.sad_ready), 0);
    tick();
    check("held_idle_busy", 32'(ia.busy), 0);
    check("held_idle_ready", 32'(ia.sad_ready), 0);
    check("held_idle_done", 32'(ia.done), 0);
    tick();
    ia.start = 1'b0;
    check("held_restart_busy", 32'(ia.busy), 1);
    check("held_restart_sad", 32'(ia.best_sad), 4095);
    check("ndone_a", 32'(nda), 4);
    check("ndone_b", 32'(ndb), 1);

    rst = 1'b1; tick(); rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
